// File: rtl/dmem_bus_ctrl.sv
// Data-memory access controller: turns a single-cycle datapath load/store into a valid/ready bus access and stalls the CPU until it completes.
// Optional feature: define MISALIGN_TRAP_EN to report misaligned half/word accesses as errors without touching the bus.
module dmem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t             state, state_next;
    logic               valid_next, we_next, err_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [31:0]        wdata_next, rdata_next;
    logic [3:0]         wstrb_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               trap;

    // Lanes past byte 3 are dropped, so unaligned halves/words are truncated.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask << off;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

    assign trap = misaligned(cpu_size, cpu_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_next = state;
        valid_next = bus_valid;
        we_next    = bus_we;
        addr_next  = bus_addr;
        wdata_next = bus_wdata;
        wstrb_next = bus_wstrb;
        rdata_next = cpu_rdata;
        err_next   = cpu_err;
        cnt_next   = cnt;
        cpu_stall  = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_re || cpu_we) begin
                    cpu_stall = 1'b1;
                    if (trap) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next = REQ;
                        valid_next = 1'b1;
                        we_next    = cpu_we;
                        addr_next  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        wdata_next = cpu_we ? lane_wdata(cpu_wdata, cpu_addr[1:0]) : '0;
                        wstrb_next = cpu_we ? lane_strobe(cpu_size, cpu_addr[1:0]) : 4'b0000;
                        err_next   = 1'b0;
                        cnt_next   = '0;
                    end
                end
            end

            REQ: begin
                cpu_stall = 1'b1;
                cnt_next  = cnt + 1'b1;
                if (bus_valid && bus_ready) begin
                    state_next = RESP;
                    valid_next = 1'b0;
                    rdata_next = bus_we ? 32'h0 : bus_rdata;
                    err_next   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RESP;
                    valid_next = 1'b0;
                    rdata_next = '0;
                    err_next   = 1'b1;
                end
            end

            RESP: begin
                // The CPU commits this cycle; returning to IDLE unconditionally keeps a held request from re-issuing.
                state_next = IDLE;
                err_next   = 1'b0;
            end

            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase

        if (!reset) begin
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            bus_valid <= valid_next;
            bus_we    <= we_next;
            bus_addr  <= addr_next;
            bus_wdata <= wdata_next;
            bus_wstrb <= wstrb_next;
            cpu_rdata <= rdata_next;
            cpu_err   <= err_next;
            cnt       <= cnt_next;
        end
    end

endmodule
